// File: rtl/counter_arb_defs.sv
// Shared definitions for the counter arbiter: FSM encoding and default sizes.
package counter_arb_defs;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_CNT_W = 4;

  // 2'd3 is unused; the FSM treats it as IDLE on the next edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cnt_down_core.sv
// Loadable down-counter that saturates at zero. Same-edge priority: clr > load > en.
module cnt_down_core #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count; the decrement is gated at zero so the value never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = load_val;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge CLK) begin
    if (RST)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin owner of a shared down-counter. Grants one requester, runs its
// length down to zero, pulses done, and returns to IDLE before rearbitrating.
//
//   state | meaning
//   IDLE  | no owner, counter held at 0, arbitration happens here only
//   RUN   | owner holds grant, counter decrements toward 0
//   DONE  | one-cycle done pulse to owner, grant still held
module counter_arbiter
  import counter_arb_defs::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*CNT_W-1:0] i_len,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;

  logic             cnt_load, cnt_en, cnt_clr, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand_idx;
  int               cand;
  logic [CNT_W-1:0] len_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign len_arr[g] = i_len[g*CNT_W +: CNT_W];
  end

  // Cyclic priority search starting just after the last owner (ptr).
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand     = (int'(ptr_q) + off) % N_REQ;
      cand_idx = PTR_W'(cand);
      if (!win_found && i_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and counter control. ptr always equals the current owner.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d         = ST_RUN;
          ptr_d           = win_idx;
          gnt_d           = '0;
          gnt_d[win_idx]  = 1'b1;
          cnt_load        = 1'b1;
        end
      end
      ST_RUN: begin
        // Abort outranks completion: a dropped request never sees done.
        if (!i_req[ptr_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          state_d = ST_DONE;
          done_d  = gnt_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_W'(N_REQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  cnt_down_core #(.CNT_W(CNT_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_load),
    .load_val (len_arr[win_idx]),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  assign o_gnt  = gnt_q;
  assign o_done = done_q;
  assign o_busy = (state_q != ST_IDLE);
  assign o_cnt  = cnt_val;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: a cycle model pushes expected outputs into a
// scoreboard as each cycle's inputs are driven; they are popped and compared
// after the edge. Directed checks cover the listed scenarios.
module tb_counter_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   i_req;
  logic [N*W-1:0] i_len;
  logic [N-1:0]   o_gnt;
  logic [N-1:0]   o_done;
  logic           o_busy;
  logic [W-1:0]   o_cnt;

  counter_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .i_req  (i_req),
    .i_len  (i_len),
    .o_gnt  (o_gnt),
    .o_done (o_done),
    .o_busy (o_busy),
    .o_cnt  (o_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         busy;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t sbq [$];

  int n_chk  = 0;
  int n_pass = 0;
  bit auto_drop = 1'b1;

  // reference model state: 0 idle, 1 run, 2 done
  int m_state = 0;
  int m_owner = 0;
  int m_cnt   = 0;
  int m_ptr   = N - 1;
  exp_t last_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
  endtask

  function automatic void model_tick(input logic r, input logic [N-1:0] req, input logic [N*W-1:0] len);
    if (r) begin
      m_state = 0; m_cnt = 0; m_ptr = N - 1;
      return;
    end
    case (m_state)
      0: begin
        for (int off = 1; off <= N; off++) begin
          int c;
          c = (m_ptr + off) % N;
          if (m_state == 0 && req[c]) begin
            m_state = 1; m_owner = c; m_ptr = c;
            m_cnt = int'((len >> (c * W)) & {{(N*W-W){1'b0}}, {W{1'b1}}});
          end
        end
      end
      1: begin
        if (!req[m_owner]) begin m_state = 0; m_cnt = 0; end
        else if (m_cnt == 0) m_state = 2;
        else m_cnt = m_cnt - 1;
      end
      default: begin m_state = 0; m_cnt = 0; end
    endcase
  endfunction

  task automatic step();
    exp_t e;
    model_tick(RST, i_req, i_len);
    e.gnt  = (m_state != 0) ? N'(1 << m_owner) : '0;
    e.done = (m_state == 2) ? N'(1 << m_owner) : '0;
    e.busy = (m_state != 0);
    e.cnt  = W'(m_cnt);
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    last_e = e;
    chk("gnt",  o_gnt,  e.gnt);
    chk("done", o_done, e.done);
    chk("busy", o_busy, e.busy);
    chk("cnt",  o_cnt,  e.cnt);
    if (auto_drop) i_req = i_req & ~e.done;
  endtask

  task automatic set_len(input int k, input int v);
    i_len[k*W +: W] = W'(v);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((i_req != '0 || m_state != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 0, 1);
  endtask

  int gnt_cycles, busy_cycles, done_cycles, n;
  logic [N-1:0] prev_gnt;
  int cseq [$];
  logic [N-1:0] order [$];

  initial begin
    RST = 1'b1; i_req = '0; i_len = '0;
    @(posedge CLK); #1;

    // reset hold with all requests high
    i_req = 4'b1111;
    for (int k = 0; k < N; k++) set_len(k, 1);
    step(); step();
    RST = 1'b0;
    step();
    chk("first_gnt", o_gnt, 4'b0001);
    drain(60);

    // single run, length 3 on requester 2
    set_len(2, 3);
    i_req = 4'b0100;
    gnt_cycles = 0;
    cseq.delete();
    n = 0;
    do begin
      step();
      if (o_gnt != '0) begin gnt_cycles++; cseq.push_back(int'(o_cnt)); end
      n++;
    end while ((o_gnt != '0) && n < 20);
    chk("single_gnt_len", gnt_cycles, 5);
    chk("single_busy_after", o_busy, 0);
    if (cseq.size() == 5) begin
      chk("single_c0", cseq[0], 3);
      chk("single_c1", cseq[1], 2);
      chk("single_c2", cseq[2], 1);
      chk("single_c3", cseq[3], 0);
    end else chk("single_seq_size", cseq.size(), 5);

    // round-robin fairness after a fresh reset
    RST = 1'b1; i_req = '0; step(); RST = 1'b0;
    auto_drop = 1'b0;
    for (int k = 0; k < N; k++) set_len(k, 1);
    i_req = 4'b1111;
    prev_gnt = '0;
    order.delete();
    n = 0;
    while (order.size() < 6 && n < 40) begin
      step();
      if (prev_gnt == '0 && o_gnt != '0) order.push_back(o_gnt);
      prev_gnt = o_gnt;
      n++;
    end
    if (order.size() == 6) begin
      chk("rr0", order[0], 4'b0001);
      chk("rr1", order[1], 4'b0010);
      chk("rr2", order[2], 4'b0100);
      chk("rr3", order[3], 4'b1000);
      chk("rr4", order[4], 4'b0001);
      chk("rr5", order[5], 4'b0010);
    end else chk("rr_timeout", order.size(), 6);
    auto_drop = 1'b1;
    drain(60);

    // zero length: one RUN cycle then DONE
    set_len(3, 0);
    i_req = 4'b1000;
    busy_cycles = 0;
    n = 0;
    do begin
      step();
      if (o_busy) busy_cycles++;
      n++;
    end while (o_busy && n < 20);
    chk("zero_busy_cycles", busy_cycles, 2);

    // abort: owner 1 drops at cnt 5, pending requester 2 then wins
    set_len(1, 9);
    set_len(2, 2);
    i_req = 4'b0010;
    step();
    i_req[2] = 1'b1;
    done_cycles = 0;
    n = 0;
    while (int'(last_e.cnt) != 5 && n < 20) begin
      step();
      if (o_done != '0) done_cycles++;
      n++;
    end
    if (n >= 20) chk("abort_wait_timeout", 0, 1);
    i_req[1] = 1'b0;
    step();
    if (o_done != '0) done_cycles++;
    chk("abort_gnt", o_gnt, 4'b0000);
    chk("abort_cnt", o_cnt, 0);
    chk("abort_no_done", done_cycles, 0);
    step();
    chk("abort_next_gnt", o_gnt, 4'b0100);
    drain(40);

    // reset mid-run, then requester 0 beats requester 3
    set_len(3, 8);
    set_len(0, 2);
    i_req = 4'b1000;
    n = 0;
    do begin step(); n++; end while (int'(last_e.cnt) != 6 && n < 20);
    if (n >= 20) chk("midrst_wait_timeout", 0, 1);
    RST = 1'b1;
    i_req = 4'b1001;
    step();
    chk("midrst_gnt", o_gnt, 4'b0000);
    chk("midrst_done", o_done, 4'b0000);
    RST = 1'b0;
    step();
    chk("midrst_winner", o_gnt, 4'b0001);
    i_req[3] = 1'b0;
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin arbiter and sequencer that shares one loadable down-counter among up to N_REQ requesters. Each requester raises a request with a run length. The arbiter grants one requester at a time, loads the counter, runs it to zero, and returns a one-cycle done pulse to the owner. It sits between the counter datapath and the blocks that need timed intervals; it is the counter's only controller.

## Interface
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 4, counter width; also the width of each length field
- CLK  in  1  clock; all logic is on posedge
- RST  in  1  reset, synchronous, active-high
- i_req  in  N_REQ  per-requester request level; held until done or abort
- i_len  in  N_REQ*CNT_W  length for requester k at bits [k*CNT_W +: CNT_W]; sampled only at grant
- o_gnt  out  N_REQ  one-hot owner, high from grant through the DONE cycle
- o_done  out  N_REQ  one-cycle pulse to the owner on completion
- o_busy  out  1  high whenever state is not IDLE
- o_cnt  out  CNT_W  current counter value; 0 in IDLE

## Operation
- FSM states:
  - IDLE: no owner, o_cnt = 0.
  - RUN: counter decrements by 1 per cycle.
  - DONE: o_done[owner] = 1, o_gnt is still held.
- IDLE → RUN on any i_req bit high. On that edge:
  - winner = first set bit searching cyclically from ptr+1;
  - o_gnt ← onehot(winner), cnt ← i_len[winner], ptr ← winner.
- RUN → DONE when cnt == 0 and i_req[owner] is still high.
- RUN → IDLE (abort) when i_req[owner] is low:
  - the abort check has priority over the cnt == 0 check;
  - no done pulse; o_gnt and cnt clear on the same edge.
- DONE → IDLE always. o_gnt and o_done clear and cnt ← 0.
- Requester rule:
  - drop i_req on the edge where o_done is sampled high;
  - i_req high in IDLE is a new request.
- Length 0 is legal: RUN lasts one cycle at cnt = 0.
- Counter never underflows. The decrement is gated by cnt != 0; wrap-around from 0 to 2^CNT_W-1 is forbidden.
- Requests arriving during RUN/DONE wait. Only IDLE arbitrates.
- Non-owner i_req changes have no effect outside IDLE.
- ptr resets to N_REQ-1, so requester 0 has top priority after reset.

## Timing
- Reset values: state IDLE, o_gnt 0, o_done 0, o_busy 0, o_cnt 0, ptr N_REQ-1.
- Reset mid-RUN or mid-DONE returns to these values on the next edge, with no done pulse.
- For a request of length L seen at edge e0:
  - o_gnt high and o_cnt = L after e0;
  - o_cnt = L-k after e0+k;
  - o_cnt = 0 after e0+L;
  - DONE (o_done = 1) after e0+L+1;
  - IDLE after e0+L+2.
- Grant duration is L+2 cycles.
- Back-to-back: the next grant is on the edge leaving IDLE, so there is at least one IDLE cycle between owners. Turnaround is 1 cycle.
- All outputs are registered. No combinational path exists from i_req or i_len to any output.

## Structure
- Shared package / include counter_arb_defs:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2; 2'd3 is illegal and recovers to IDLE;
  - default N_REQ and CNT_W.
- Sub-module cnt_down_core, parameter CNT_W:
  - ports CLK, RST, load, load_val, en, clr, cnt, zero;
  - priority on the same edge: clr > load > en.
- Top level holds:
  - the FSM;
  - the round-robin pointer;
  - the cyclic priority search, as a rotate-then-priority-encode or a loop over N_REQ;
  - the length mux.

## Test plan
- **Reset hold:** RST high 2 cycles with i_req = 4'b1111 → all outputs 0 throughout. First grant after release is o_gnt = 4'b0001.
- **Single run:** i_req = 4'b0100, i_len[2] = 3 → o_cnt sequence 3, 2, 1, 0. o_done = 4'b0100 on the following cycle. o_gnt is high for 5 cycles, then o_busy drops.
- **Round-robin fairness:** all four requesters always re-request with length 1 → grant order 0, 1, 2, 3, 0, … Each grant lasts 3 cycles with a 1-cycle IDLE gap.
- **Zero length:** i_req = 4'b1000, i_len[3] = 0 → one RUN cycle at o_cnt = 0, then o_done = 4'b1000. No wrap to 15.
- **Abort:** owner 1 with length 9 drops i_req when o_cnt = 5 → next edge IDLE, o_gnt = 0, o_cnt = 0, o_done never pulses. A pending requester 2 is granted on the following edge.
- **Reset mid-run:** RST asserted while o_cnt = 6 → all outputs 0 next edge, no done. After release, ptr = N_REQ-1, so requester 0 wins against requester 3.
